// File: rtl/striping_tx.sv
// -----------------------------------------------------------------------------
// striping_tx
//   Transmit side of the 4-lane link. Bytes arriving over a valid/ready
//   handshake are collected into a 4-slot stripe buffer; slot k always goes out
//   on lane k. Once all four slots are full, the group is loaded into the lane
//   shift registers at the next frame boundary and sent MSB-first, one bit per
//   clock, in 8-cycle symbol frames. Lanes carry the IDLE_SYM comma whenever no
//   complete group is ready. A flush pads an incomplete group with PAD_SYM so
//   it can go out.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   enb          global enable; low freezes every register
//   in_data      byte offered by the upstream source
//   in_valid     in_data is valid
//   in_ready     a byte can be accepted on this edge
//   flush        pad and close an incomplete stripe group
//   L0..L3       serial lane bits (MSB of each lane shift register)
//   frame_start  bit 7 of a symbol is on the lanes
//   data_frame   the current symbol is data rather than idle
//   busy         stripe buffer non-empty or a data frame in flight
// -----------------------------------------------------------------------------
module striping_tx #(
    parameter logic [7:0] IDLE_SYM = 8'hBC,
    parameter logic [7:0] PAD_SYM  = 8'hF7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic       L0,
    output logic       L1,
    output logic       L2,
    output logic       L3,
    output logic       frame_start,
    output logic       data_frame,
    output logic       busy
);

    localparam int NUM_LANES = 4;

    logic [7:0] slot_q [NUM_LANES];
    logic [7:0] slot_d [NUM_LANES];
    logic [7:0] lane_q [NUM_LANES];
    logic [7:0] lane_d [NUM_LANES];
    logic [2:0] fill_q, fill_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       data_frame_q, data_frame_d;

    logic frame_edge;
    logic accept;

    assign frame_edge = (bit_cnt_q == 3'd7);

    // A full buffer may still take a byte on the frame edge, because that same
    // edge moves the group into the lanes and frees slot 0.
    assign in_ready = enb & reset & ((fill_q < 3'd4) | frame_edge);
    assign accept   = in_valid & in_ready;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves a
        // variable unassigned; that is what keeps latches from being inferred.
        slot_d       = slot_q;
        lane_d       = lane_q;
        fill_d       = fill_q;
        bit_cnt_d    = bit_cnt_q;
        data_frame_d = data_frame_q;

        if (enb) begin
            if (frame_edge) begin
                bit_cnt_d = 3'd0;
                // The load decision uses the pre-edge fill: a group completed
                // on this edge waits for the next frame (no bypass).
                if (fill_q == 3'd4) begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        lane_d[k] = slot_q[k];
                    end
                    data_frame_d = 1'b1;
                    fill_d       = 3'd0;
                end else begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        lane_d[k] = IDLE_SYM;
                    end
                    data_frame_d = 1'b0;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                for (int k = 0; k < NUM_LANES; k++) begin
                    lane_d[k] = {lane_q[k][6:0], 1'b0};
                end
            end

            // Accept and flush act on the buffer as left by the frame logic
            // above (emptied on a data load, otherwise unchanged).
            if (accept) begin
                slot_d[fill_d[1:0]] = in_data;
                fill_d              = fill_d + 3'd1;
            end

            if (flush && (fill_d != 3'd0) && (fill_d < 3'd4)) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (3'(k) >= fill_d) begin
                        slot_d[k] = PAD_SYM;
                    end
                end
                fill_d = 3'd4;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the comb block above uses blocking ones
    // because it computes a chain of intermediate values in order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_q[k] <= IDLE_SYM;
            end
            fill_q       <= 3'd0;
            bit_cnt_q    <= 3'd0;
            data_frame_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            fill_q       <= fill_d;
            bit_cnt_q    <= bit_cnt_d;
            data_frame_q <= data_frame_d;
        end
    end

    // NOTE: the slot storage is deliberately not reset; fill_q alone says
    // which slots are meaningful, and every slot is rewritten before it is
    // ever loaded into a lane.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign L0          = lane_q[0][7];
    assign L1          = lane_q[1][7];
    assign L2          = lane_q[2][7];
    assign L3          = lane_q[3][7];
    assign frame_start = (bit_cnt_q == 3'd0);
    assign data_frame  = data_frame_q;
    assign busy        = (fill_q != 3'd0) | data_frame_q;

endmodule

// File: tb/tb_striping_tx.sv
// -----------------------------------------------------------------------------
// tb_striping_tx
//   Directed bench for striping_tx. Inputs change 1 time unit after a rising
//   edge and outputs are sampled at that same point, well clear of the edge.
//   Expected lane bytes are written out by hand for each scenario.
// -----------------------------------------------------------------------------
module tb_striping_tx;

    localparam logic [7:0] IDLE = 8'hBC;
    localparam logic [7:0] PAD  = 8'hF7;

    logic       clk;
    logic       reset;
    logic       enb;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic       L0, L1, L2, L3;
    logic       frame_start;
    logic       data_frame;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    striping_tx dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .L0         (L0),
        .L1         (L1),
        .L2         (L2),
        .L3         (L3),
        .frame_start(frame_start),
        .data_frame (data_frame),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until accepted; returns the stall cycles.
    task automatic send(input logic [7:0] b, output int stalls);
        int n;
        n         = 0;
        in_data   = b;
        in_valid  = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        stalls   = n;
    endtask

    task automatic send4(input logic [7:0] b0, b1, b2, b3);
        int s;
        send(b0, s);
        send(b1, s);
        send(b2, s);
        send(b3, s);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Wait (at most 'bound' cycles) for a frame start, then collect the 8 bits
    // of each lane. stall_at >= 0 drops enb for 5 cycles after that bit.
    task automatic capture(input string tag, input int bound,
                           input logic [7:0] e0, e1, e2, e3,
                           input logic exp_df, input int stall_at);
        int         n;
        logic [7:0] b0, b1, b2, b3;
        logic [3:0] held;
        n = 0;
        while (!frame_start && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_start"}, frame_start, 1'b1);
        check({tag, "_df"}, data_frame, exp_df);
        b0 = '0; b1 = '0; b2 = '0; b3 = '0;
        for (int i = 0; i < 8; i++) begin
            b0 = {b0[6:0], L0};
            b1 = {b1[6:0], L1};
            b2 = {b2[6:0], L2};
            b3 = {b3[6:0], L3};
            if (i == stall_at) begin
                held     = {L3, L2, L1, L0};
                enb      = 1'b0;
                in_valid = 1'b1;
                in_data  = 8'hEE;
                #1;
                check({tag, "_stall_rdy0"}, in_ready, 1'b0);
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check({tag, "_stall_lanes"}, {L3, L2, L1, L0}, held);
                    check({tag, "_stall_rdy"}, in_ready, 1'b0);
                    check({tag, "_stall_fs"}, frame_start, 1'b0);
                end
                enb      = 1'b1;
                in_valid = 1'b0;
            end
            if (i < 7) tick();
        end
        check({tag, "_L0"}, b0, e0);
        check({tag, "_L1"}, b1, e1);
        check({tag, "_L2"}, b2, e2);
        check({tag, "_L3"}, b3, e3);
        check({tag, "_df_end"}, data_frame, exp_df);
    endtask

    initial begin
        logic [7:0] idle_v;
        int         st0, st4, st8, s;

        idle_v   = IDLE;
        reset    = 1'b0;
        enb      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        flush    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_lanes", {L3, L2, L1, L0}, 4'hF);
        check("rst_fs", frame_start, 1'b1);
        check("rst_rdy", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_df", data_frame, 1'b0);
        #3 reset = 1'b1;

        // 1. Idle stream for 24 cycles
        for (int c = 0; c < 24; c++) begin
            check("idle_lanes", {L3, L2, L1, L0}, idle_v[7 - (c % 8)] ? 4'hF : 4'h0);
            check("idle_fs", frame_start, (c % 8) == 0);
            check("idle_df", data_frame, 1'b0);
            check("idle_busy", busy, 1'b0);
            tick();
        end

        // 2. One group, then an idle frame
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        check("grp_busy", busy, 1'b1);
        capture("grp", 10, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, -1);
        capture("grp_idle", 1, IDLE, IDLE, IDLE, IDLE, 1'b0, -1);

        // 3. Twelve bytes under continuous valid; starts on a bit_cnt==7 cycle
        fork
            begin
                send(8'h00, st0);
                send(8'h01, s); send(8'h02, s); send(8'h03, s);
                send(8'h04, st4);
                send(8'h05, s); send(8'h06, s); send(8'h07, s);
                send(8'h08, st8);
                send(8'h09, s); send(8'h0A, s); send(8'h0B, s);
            end
            begin
                capture("str_idle", 1, IDLE, IDLE, IDLE, IDLE, 1'b0, -1);
                capture("str_f1", 1, 8'h00, 8'h01, 8'h02, 8'h03, 1'b1, -1);
                capture("str_f2", 1, 8'h04, 8'h05, 8'h06, 8'h07, 1'b1, -1);
                capture("str_f3", 1, 8'h08, 8'h09, 8'h0A, 8'h0B, 1'b1, -1);
            end
        join
        check("str_stall0", st0, 0);
        check("str_stall4", st4, 4);
        check("str_stall8", st8, 4);
        capture("str_after", 1, IDLE, IDLE, IDLE, IDLE, 1'b0, -1);
        check("str_busy", busy, 1'b0);

        // 4. Flush a two-byte partial group, then flush with an empty buffer
        send(8'hA1, s);
        send(8'hA2, s);
        pulse_flush();
        capture("fl", 10, 8'hA1, 8'hA2, PAD, PAD, 1'b1, -1);
        tick();
        pulse_flush();
        check("fl0_busy", busy, 1'b0);
        capture("fl0", 10, IDLE, IDLE, IDLE, IDLE, 1'b0, -1);
        check("fl0_busy2", busy, 1'b0);

        // 5. Enable drop at bit_cnt 3 of a data frame
        send4(8'h5A, 8'hC3, 8'h0F, 8'h81);
        capture("enb", 10, 8'h5A, 8'hC3, 8'h0F, 8'h81, 1'b1, 3);
        capture("enb_idle", 1, IDLE, IDLE, IDLE, IDLE, 1'b0, -1);
        check("enb_busy", busy, 1'b0);

        // 6. Reset at bit_cnt 5 of a data frame with two bytes buffered
        send4(8'h00, 8'h00, 8'h00, 8'h00);
        s = 0;
        while (!frame_start && s < 10) begin
            tick();
            s++;
        end
        check("rm_df", data_frame, 1'b1);
        send(8'h99, s);
        send(8'h66, s);
        repeat (3) tick();
        check("rm_pre_lanes", {L3, L2, L1, L0}, 4'h0);
        check("rm_pre_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rm_lanes", {L3, L2, L1, L0}, 4'hF);
        check("rm_fs", frame_start, 1'b1);
        check("rm_df0", data_frame, 1'b0);
        check("rm_busy", busy, 1'b0);
        check("rm_rdy", in_ready, 1'b0);
        repeat (2) tick();
        #3 reset = 1'b1;
        capture("rm_idle", 0, IDLE, IDLE, IDLE, IDLE, 1'b0, -1);
        check("rm_idle_busy", busy, 1'b0);
        tick();
        send(8'h12, s);
        send(8'h34, s);
        pulse_flush();
        capture("rm_new", 10, 8'h12, 8'h34, PAD, PAD, 1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
